// File: rtl/framebuffer_readback_tx_pkg.sv
// readback_pkg: shared FSM encoding and UART framing constants for the framebuffer readback path.
// Optional feature macro: READBACK_HEADER_EN (adds the HDR state). Rev 1.0
`default_nettype none

package readback_pkg;

  localparam logic [7:0] READBACK_SYNC_BYTE = 8'hA5;
  localparam int         UART_FRAME_BITS    = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
`ifdef READBACK_HEADER_EN
    ST_HDR    = 3'd1,
`endif
    ST_FETCH  = 3'd2,
    ST_SEND   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/framebuffer_readback_tx_uart.sv
// readback_uart_tx: 8N1 serialiser; ready rises in the last stop-bit cycle so frames chain gaplessly.
// Rev 1.0
`default_nettype none

module readback_uart_tx
  import readback_pkg::*;
#(
  parameter int TICKS_PER_BIT = 9
) (
  input  logic       clk_in,
  input  logic       rstb,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx_out
);

  localparam int                TICK_W    = $clog2(TICKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(UART_FRAME_BITS - 1);

  logic [TICK_W-1:0]          tick;
  logic [3:0]                 bit_idx;
  logic [UART_FRAME_BITS-1:0] shreg;
  logic                       active;

  // The line is shreg[0]; idle shifter is all ones so the line rests high.
  assign tx_out = shreg[0];
  assign ready  = !active || ((tick == TICK_LAST) && (bit_idx == BIT_LAST));

  always_ff @(posedge clk_in or negedge rstb) begin
    if (!rstb) begin
      shreg   <= '1;
      tick    <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
    end else if (load && ready) begin
      shreg   <= {1'b1, data, 1'b0};
      tick    <= '0;
      bit_idx <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (tick == TICK_LAST) begin
        tick <= '0;
        if (bit_idx == BIT_LAST) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shreg   <= {1'b1, shreg[UART_FRAME_BITS-1:1]};
        end
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/framebuffer_readback_tx.sv
// framebuffer_readback_tx: streams a RAM byte range out over UART 8N1, sharing RAM port A by req/gnt.
// Optional feature macro: READBACK_HEADER_EN (3-byte sync/length header per dump). Rev 1.0
`default_nettype none

module framebuffer_readback_tx
  import readback_pkg::*;
#(
  parameter  int PIXEL_WIDTH     = 64,
  parameter  int PIXEL_HEIGHT    = 32,
  parameter  int BYTES_PER_PIXEL = 2,
  parameter  int TICKS_PER_BIT   = 9,
  localparam int ADDR_W          = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL)
) (
  input  logic              clk_in,
  input  logic              rstb,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              ram_req,
  input  logic              ram_gnt,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_clk_enable,
  input  logic [7:0]        ram_data_in,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t          state;
  logic [ADDR_W:0] fetch_cnt;
  logic [ADDR_W:0] send_cnt;
  logic            rd_inflight;
  logic            hold_valid;
  logic [7:0]      hold;
  logic [7:0]      byte_data;
  logic [7:0]      uart_data;
  logic            byte_avail;
  logic            load_ram;
  logic            load_hdr;
  logic            uart_load;
  logic            uart_ready;

  // One byte may be in flight or held at a time; a read is only issued into an empty slot.
  assign ram_clk_enable = ram_req && ram_gnt && !hold_valid && !rd_inflight;
  assign byte_avail     = hold_valid || rd_inflight;
  assign byte_data      = hold_valid ? hold : ram_data_in;
  assign load_ram       = ((state == ST_FETCH) || (state == ST_SEND)) && uart_ready
                          && byte_avail && (send_cnt != '0);
  assign uart_load      = load_ram || load_hdr;

`ifdef READBACK_HEADER_EN
  logic [15:0] hdr_len;
  logic [1:0]  hdr_idx;

  assign load_hdr = ((state == ST_HDR) && uart_ready)
                    || ((state == ST_IDLE) && start && (length != '0));

  always_comb begin
    uart_data = byte_data;
    if (!load_ram) begin
      if (state == ST_HDR) uart_data = (hdr_idx == 2'd1) ? hdr_len[15:8] : hdr_len[7:0];
      else                 uart_data = READBACK_SYNC_BYTE;
    end
  end
`else
  assign load_hdr  = 1'b0;
  assign uart_data = byte_data;
`endif

  always_ff @(posedge clk_in or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_req     <= 1'b0;
      ram_address <= '0;
      fetch_cnt   <= '0;
      send_cnt    <= '0;
      rd_inflight <= 1'b0;
      hold_valid  <= 1'b0;
      hold        <= '0;
`ifdef READBACK_HEADER_EN
      hdr_len     <= '0;
      hdr_idx     <= '0;
`endif
    end else begin
      done        <= 1'b0;
      rd_inflight <= ram_clk_enable;
      if (ram_clk_enable) begin
        ram_address <= ram_address + 1'b1;
        fetch_cnt   <= fetch_cnt - 1'b1;
        if (fetch_cnt == CNT_ONE) ram_req <= 1'b0;
      end
      // Returning data bypasses the holding register when the shifter can take it at once.
      if (load_ram) begin
        send_cnt   <= send_cnt - 1'b1;
        hold_valid <= 1'b0;
      end else if (rd_inflight) begin
        hold       <= ram_data_in;
        hold_valid <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              busy        <= 1'b1;
              ram_req     <= 1'b1;
              ram_address <= start_addr;
              fetch_cnt   <= length;
              send_cnt    <= length;
`ifdef READBACK_HEADER_EN
              hdr_len     <= 16'(length);
              hdr_idx     <= 2'd1;
              state       <= ST_HDR;
`else
              state       <= ST_FETCH;
`endif
            end
          end
        end
`ifdef READBACK_HEADER_EN
        ST_HDR: begin
          if (uart_ready) begin
            if (hdr_idx == 2'd2) state <= ST_SEND;
            else                 hdr_idx <= hdr_idx + 2'd1;
          end
        end
`endif
        ST_FETCH: begin
          if (load_ram) state <= ST_SEND;
        end
        ST_SEND: begin
          if ((send_cnt == '0) && uart_ready) begin
            state <= ST_FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  readback_uart_tx #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_uart (
    .clk_in (clk_in),
    .rstb   (rstb),
    .load   (uart_load),
    .data   (uart_data),
    .ready  (uart_ready),
    .tx_out (tx_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_readback_tx.sv
// tb_framebuffer_readback_tx: randomized self-checking bench with a RAM model and a UART line decoder.
// Follows READBACK_HEADER_EN when defined.
`timescale 1ns/1ps
`default_nettype none

module tb_framebuffer_readback_tx;

  localparam int T      = 9;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int FRAME  = 10 * T;
`ifdef READBACK_HEADER_EN
  localparam int HDR_N = 3;
  localparam int FIRST_START = 1;
`else
  localparam int HDR_N = 0;
  localparam int FIRST_START = 3;
`endif

  logic              clk_in = 1'b0;
  logic              rstb = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic              ram_req;
  logic              ram_gnt = 1'b1;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_clk_enable;
  logic [7:0]        ram_data_in;
  logic              tx_out;
  logic              busy;
  logic              done;

  framebuffer_readback_tx #(
    .PIXEL_WIDTH(64), .PIXEL_HEIGHT(32), .BYTES_PER_PIXEL(2), .TICKS_PER_BIT(T)
  ) dut (
    .clk_in(clk_in), .rstb(rstb), .start(start), .start_addr(start_addr), .length(length),
    .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_address(ram_address),
    .ram_clk_enable(ram_clk_enable), .ram_data_in(ram_data_in),
    .tx_out(tx_out), .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  typedef logic [7:0] byte_q_t[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  logic [7:0] mem [DEPTH];
  logic [7:0] ram_q = 8'h00;
  assign ram_data_in = ram_q;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (ram_clk_enable) ram_q <= mem[ram_address];
  end

  int gnt_mode = 0;
  int gnt_lo = 0;
  int gnt_hi = 0;
  initial forever begin
    @(posedge clk_in);
    #2;
    case (gnt_mode)
      0:       ram_gnt = 1'b1;
      1:       ram_gnt = ($urandom_range(0, 9) < 7);
      default: ram_gnt = !(((cyc - t0) >= gnt_lo) && ((cyc - t0) < gnt_hi));
    endcase
  end

  logic [ADDR_W-1:0] strobe_addr_q[$];
  int strobe_rel_q[$];
  int done_rel_q[$];
  int strobe_viol = 0;
  logic busy_at_done = 1'b0, busy_at1 = 1'b0, req_at1 = 1'b0;
  bit busy_seen = 0, req_seen = 0, tx_low_seen = 0;

  initial forever begin
    @(negedge clk_in);
    if (ram_clk_enable === 1'b1) begin
      if (ram_gnt !== 1'b1) strobe_viol++;
      strobe_addr_q.push_back(ram_address);
      strobe_rel_q.push_back(cyc - t0);
    end
    if (done === 1'b1) begin
      done_rel_q.push_back(cyc - t0);
      busy_at_done = busy;
    end
    if (busy === 1'b1) busy_seen = 1;
    if (ram_req === 1'b1) req_seen = 1;
    if (tx_out !== 1'b1) tx_low_seen = 1;
    if ((cyc - t0) == 1) begin
      busy_at1 = busy;
      req_at1  = ram_req;
    end
  end

  // Line decoder: samples each bit at its centre, independent of DUT internals.
  logic [7:0] rx_q[$];
  int rx_rel_q[$];
  int rx_stop_bad = 0;
  initial forever begin
    @(negedge clk_in);
    if (tx_out === 1'b0) begin
      int s;
      logic [7:0] b;
      s = cyc - t0;
      repeat (T / 2) @(negedge clk_in);
      for (int i = 0; i < 8; i++) begin
        repeat (T) @(negedge clk_in);
        b[i] = tx_out;
      end
      repeat (T) @(negedge clk_in);
      if (tx_out !== 1'b1) rx_stop_bad++;
      rx_q.push_back(b);
      rx_rel_q.push_back(s);
    end
  end

  function automatic byte_q_t exp_stream(input logic [ADDR_W-1:0] a, input int n);
    byte_q_t q;
`ifdef READBACK_HEADER_EN
    logic [15:0] l16;
    l16 = 16'(n);
    q.push_back(8'hA5);
    q.push_back(l16[15:8]);
    q.push_back(l16[7:0]);
`endif
    for (int i = 0; i < n; i++) q.push_back(mem[(int'(a) + i) % DEPTH]);
    return q;
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    rx_rel_q.delete();
    strobe_addr_q.delete();
    strobe_rel_q.delete();
    done_rel_q.delete();
    strobe_viol = 0;
    rx_stop_bad = 0;
    busy_seen = 0;
    req_seen = 0;
    tx_low_seen = 0;
    busy_at1 = 1'b0;
    req_at1 = 1'b0;
  endtask

  task automatic do_dump(input logic [ADDR_W-1:0] a, input int n, input int budget,
                         input bit poke, output bit timeout);
    clear_mon();
    @(negedge clk_in);
    start = 1'b1;
    start_addr = a;
    length = (ADDR_W+1)'(n);
    t0 = cyc;
    timeout = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      start = poke && (i == 20);
      if (start) begin
        start_addr = a + 12'h100;
        length = 13'd5;
      end
      if (done === 1'b1) begin
        timeout = 0;
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    checks++; if (tx_out !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ram_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", ram_req); end
    checks++; if (ram_clk_enable !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b expected 0", ram_clk_enable); end
    checks++; if (ram_address !== '0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", ram_address); end
    rstb = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_basic();
    byte_q_t exp;
    bit to;
    mem[12'h010] = 8'h11; mem[12'h011] = 8'h22; mem[12'h012] = 8'h33;
    gnt_mode = 0;
    do_dump(12'h010, 3, 2000, 1'b1, to);
    exp = exp_stream(12'h010, 3);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout: got timeout expected done"); end
    checks++; if (done_rel_q.size() != 1 || done_rel_q[0] != FIRST_START + FRAME * (3 + HDR_N)) begin
      failures++; $display("FAIL basic_done_cycle: got %0d (n=%0d) expected %0d", done_rel_q.size() ? done_rel_q[0] : -1, done_rel_q.size(), FIRST_START + FRAME * (3 + HDR_N)); end
    checks++; if (busy_at_done !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
    checks++; if (busy_at1 !== 1'b1 || req_at1 !== 1'b1) begin failures++; $display("FAIL basic_cycle1: got busy=%b req=%b expected 1 1", busy_at1, req_at1); end
    checks++; if (strobe_rel_q.size() != 3 || strobe_rel_q[0] != 1) begin
      failures++; $display("FAIL basic_strobes: got n=%0d first=%0d expected n=3 first=1", strobe_rel_q.size(), strobe_rel_q.size() ? strobe_rel_q[0] : -1); end
    checks++; if (rx_rel_q.size() == 0 || rx_rel_q[0] != FIRST_START) begin
      failures++; $display("FAIL basic_first_start: got %0d expected %0d", rx_rel_q.size() ? rx_rel_q[0] : -1, FIRST_START); end
    checks++; if (rx_q.size() != exp.size()) begin failures++; $display("FAIL basic_count: got %0d expected %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL basic_byte%0d: got %0h expected %0h", i, rx_q[i], exp[i]); end
    end
    for (int i = 1; i < rx_rel_q.size(); i++) begin
      checks++; if (rx_rel_q[i] - rx_rel_q[i-1] != FRAME) begin
        failures++; $display("FAIL basic_gapless%0d: got spacing %0d expected %0d", i, rx_rel_q[i] - rx_rel_q[i-1], FRAME); end
    end
    checks++; if (rx_stop_bad != 0) begin failures++; $display("FAIL basic_stop: got %0d bad stop bits expected 0", rx_stop_bad); end
  endtask

  task automatic test_zero_length();
    bit to;
    gnt_mode = 0;
    do_dump(12'($urandom), 0, 20, 1'b0, to);
    checks++; if (to || done_rel_q.size() != 1 || done_rel_q[0] != 1) begin
      failures++; $display("FAIL zero_done: got n=%0d first=%0d expected n=1 at cycle 1", done_rel_q.size(), done_rel_q.size() ? done_rel_q[0] : -1); end
    checks++; if (busy_seen || req_seen || tx_low_seen) begin
      failures++; $display("FAIL zero_quiet: got busy=%0d req=%0d tx_low=%0d expected 0 0 0", busy_seen, req_seen, tx_low_seen); end
    checks++; if (strobe_addr_q.size() != 0) begin failures++; $display("FAIL zero_strobe: got %0d strobes expected 0", strobe_addr_q.size()); end
  endtask

  task automatic test_wrap();
    byte_q_t exp;
    bit to;
    gnt_mode = 0;
    do_dump(12'hFFF, 2, 2000, 1'b0, to);
    exp = exp_stream(12'hFFF, 2);
    checks++; if (to || strobe_addr_q.size() != 2 || strobe_addr_q[0] !== 12'hFFF || strobe_addr_q[1] !== 12'h000) begin
      failures++; $display("FAIL wrap_addr: got n=%0d %0h %0h expected 2 fff 0", strobe_addr_q.size(),
                           strobe_addr_q.size() > 0 ? strobe_addr_q[0] : 12'hx, strobe_addr_q.size() > 1 ? strobe_addr_q[1] : 12'hx); end
    checks++; if (rx_q.size() != exp.size()) begin failures++; $display("FAIL wrap_count: got %0d expected %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL wrap_byte%0d: got %0h expected %0h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_gnt_stall();
    byte_q_t exp;
    bit to;
    logic [ADDR_W-1:0] a;
    a = 12'($urandom);
    gnt_lo = FIRST_START + FRAME * HDR_N;
    gnt_hi = gnt_lo + 150;
    gnt_mode = 2;
    do_dump(a, 3, 3000, 1'b0, to);
    gnt_mode = 0;
    exp = exp_stream(a, 3);
    checks++; if (to) begin failures++; $display("FAIL stall_timeout: got timeout expected done"); end
    checks++; if (strobe_viol != 0) begin failures++; $display("FAIL stall_strobe_no_gnt: got %0d expected 0", strobe_viol); end
    checks++; if (rx_rel_q.size() < HDR_N + 2 || rx_rel_q[HDR_N+1] - rx_rel_q[HDR_N] <= FRAME) begin
      failures++; $display("FAIL stall_gap: got spacing %0d expected more than %0d",
                           rx_rel_q.size() >= HDR_N + 2 ? rx_rel_q[HDR_N+1] - rx_rel_q[HDR_N] : -1, FRAME); end
    checks++; if (rx_q.size() != exp.size()) begin failures++; $display("FAIL stall_count: got %0d expected %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL stall_byte%0d: got %0h expected %0h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_abort();
    byte_q_t exp;
    bit to;
    logic [ADDR_W-1:0] a;
    gnt_mode = 0;
    clear_mon();
    @(negedge clk_in);
    start = 1'b1; start_addr = 12'($urandom); length = 13'd3; t0 = cyc;
    @(negedge clk_in);
    start = 1'b0;
    while ((cyc - t0) < FIRST_START + FRAME * (HDR_N + 1) + 40) @(negedge clk_in);
    rstb = 1'b0;
    #1;
    checks++; if (tx_out !== 1'b1 || ram_req !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_immediate: got tx=%b req=%b busy=%b expected 1 0 0", tx_out, ram_req, busy); end
    repeat (3) @(negedge clk_in);
    rstb = 1'b1;
    repeat (12 * T) @(negedge clk_in);
    checks++; if (done_rel_q.size() != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_rel_q.size()); end
    a = 12'($urandom);
    do_dump(a, 2, 2000, 1'b0, to);
    exp = exp_stream(a, 2);
    checks++; if (to || done_rel_q.size() != 1 || done_rel_q[0] != FIRST_START + FRAME * (2 + HDR_N)) begin
      failures++; $display("FAIL abort_restart_done: got %0d expected %0d", done_rel_q.size() ? done_rel_q[0] : -1, FIRST_START + FRAME * (2 + HDR_N)); end
    checks++; if (rx_q.size() != exp.size()) begin failures++; $display("FAIL abort_restart_count: got %0d expected %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL abort_restart_byte%0d: got %0h expected %0h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    byte_q_t exp;
    bit to;
    logic [ADDR_W-1:0] a;
    int n;
    for (int it = 0; it < 4; it++) begin
      a = 12'($urandom);
      n = $urandom_range(1, 5);
      gnt_mode = 1;
      do_dump(a, n, 6000, 1'b0, to);
      gnt_mode = 0;
      exp = exp_stream(a, n);
      checks++; if (to || done_rel_q.size() != 1) begin failures++; $display("FAIL rand%0d_done: got %0d pulses expected 1", it, done_rel_q.size()); end
      checks++; if (strobe_viol != 0 || strobe_addr_q.size() != n) begin
        failures++; $display("FAIL rand%0d_strobes: got viol=%0d n=%0d expected 0 %0d", it, strobe_viol, strobe_addr_q.size(), n); end
      checks++; if (rx_q.size() != exp.size()) begin failures++; $display("FAIL rand%0d_count: got %0d expected %0d", it, rx_q.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
        checks++; if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL rand%0d_byte%0d: got %0h expected %0h", it, i, rx_q[i], exp[i]); end
      end
    end
  endtask

`ifdef READBACK_HEADER_EN
  task automatic test_header();
    bit to;
    logic [ADDR_W-1:0] a;
    logic [7:0] want [7];
    a = 12'($urandom);
    want[0] = 8'hA5; want[1] = 8'h00; want[2] = 8'h04;
    for (int i = 0; i < 4; i++) want[3+i] = mem[(int'(a) + i) % DEPTH];
    gnt_mode = 0;
    do_dump(a, 4, 2000, 1'b0, to);
    checks++; if (to || rx_q.size() != 7) begin failures++; $display("FAIL hdr_count: got %0d expected 7", rx_q.size()); end
    for (int i = 0; i < 7 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== want[i]) begin failures++; $display("FAIL hdr_byte%0d: got %0h expected %0h", i, rx_q[i], want[i]); end
    end
    checks++; if (rx_rel_q.size() != 7 || rx_rel_q[6] - rx_rel_q[0] != 6 * FRAME) begin
      failures++; $display("FAIL hdr_gapless: got span %0d expected %0d", rx_rel_q.size() == 7 ? rx_rel_q[6] - rx_rel_q[0] : -1, 6 * FRAME); end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_zero_length();
    test_wrap();
    test_gnt_stall();
    test_abort();
    test_random();
`ifdef READBACK_HEADER_EN
    test_header();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
